// File: rtl/rv_wb_pkg.sv
// Shared definitions for the register writeback queue: default widths,
// the hardwired-zero register address and the buffered request layout.
package rv_wb_pkg;
  localparam int WB_AW = 2;
  localparam int WB_DW = 32;
  localparam logic [WB_AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [WB_AW-1:0] addr;
    logic [WB_DW-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/wb_fifo_2w1r.sv
// Circular buffer accepting up to two pushes (a ahead of b) and one pop per cycle.
// The caller guarantees pushes never overflow and pops never underflow.
module wb_fifo_2w1r #(
  parameter int DEPTH = 4,
  parameter int W     = 34
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push_a,
  input  logic [W-1:0]             data_a,
  input  logic                     push_b,
  input  logic [W-1:0]             data_b,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr;

  always_comb begin
    mem_d = mem_q;
    wr    = wr_ptr_q;
    if (push_a) begin
      mem_d[wr] = data_a;
      wr        = wr + PW'(1);
    end
    if (push_b) begin
      mem_d[wr] = data_b;
      wr        = wr + PW'(1);
    end
    wr_ptr_d = wr;
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push_a) + CW'(push_b) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
endmodule

// File: rtl/regfile_wb_queue.sv
// Writeback queue in front of the register file: ALU/LSU intake, in-order
// drain into a registered write port, and per-register pending-write flags.
module regfile_wb_queue
  import rv_wb_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int AW        = WB_AW,
  parameter int DW        = WB_DW,
  parameter bit ZERO_DROP = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [AW-1:0]          alu_addr,
  input  logic [DW-1:0]          alu_data,
  input  logic                   lsu_valid,
  output logic                   lsu_ready,
  input  logic [AW-1:0]          lsu_addr,
  input  logic [DW-1:0]          lsu_data,
  input  logic                   hold,
  output logic                   we,
  output logic [AW-1:0]          waddr,
  output logic [DW-1:0]          wdata,
  output logic [2**AW-1:0]       busy,
  output logic [$clog2(DEPTH):0] count
);
  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int NR  = 2**AW;
  localparam int PCW = $clog2(DEPTH + 2);

  logic [CW-1:0]    free;
  logic             lsu_push, alu_push, pop;
  logic [AW+DW-1:0] head;
  logic [AW-1:0]    head_addr;
  logic [DW-1:0]    head_data;

  logic             we_q, we_d;
  logic [AW-1:0]    waddr_q, waddr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic             out_vld_q, out_vld_d;
  logic [PCW-1:0]   pending_q [NR];
  logic [PCW-1:0]   pending_d [NR];

  // Credit comes only from the registered count, so a full queue never
  // pushes and pops in the same cycle.
  assign free      = CW'(DEPTH) - count;
  assign lsu_ready = (free != '0);
  assign alu_ready = (free >= CW'(2)) | (lsu_ready & ~lsu_valid);
  assign lsu_push  = lsu_valid & lsu_ready;
  assign alu_push  = alu_valid & alu_ready;
  assign pop       = ~hold & (count != '0);

  wb_fifo_2w1r #(
    .DEPTH (DEPTH),
    .W     (AW + DW)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_a  (lsu_push),
    .data_a  ({lsu_addr, lsu_data}),
    .push_b  (alu_push),
    .data_b  ({alu_addr, alu_data}),
    .pop     (pop),
    .head    (head),
    .count   (count)
  );

  assign head_addr = head[AW+DW-1:DW];
  assign head_data = head[DW-1:0];

  always_comb begin
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    out_vld_d = pop;
    if (pop) begin
      we_d    = !(ZERO_DROP && (head_addr == AW'(REG_ZERO)));
      waddr_d = head_addr;
      wdata_d = head_data;
    end
    // Output register retires the cycle after it is loaded, dropped or not.
    for (int r = 0; r < NR; r++) begin
      pending_d[r] = pending_q[r]
                   + PCW'(lsu_push && (lsu_addr == AW'(r)))
                   + PCW'(alu_push && (alu_addr == AW'(r)))
                   - PCW'(out_vld_q && (waddr_q == AW'(r)));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      out_vld_q <= 1'b0;
      for (int r = 0; r < NR; r++) pending_q[r] <= '0;
    end else begin
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      out_vld_q <= out_vld_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    busy = '0;
    for (int r = 0; r < NR; r++) busy[r] = |pending_q[r];
  end

  assign we    = we_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;
endmodule

// File: tb/tb_regfile_wb_queue.sv
// Self-checking bench for regfile_wb_queue: directed scenarios plus random
// traffic compared cycle by cycle against a queue-based reference model.
module tb_regfile_wb_queue;
  import rv_wb_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n, alu_valid, lsu_valid, hold;
  logic [1:0]  alu_addr, lsu_addr;
  logic [31:0] alu_data, lsu_data;
  logic        alu_ready, lsu_ready, we;
  logic [1:0]  waddr;
  logic [31:0] wdata;
  logic [3:0]  busy;
  logic [2:0]  count;

  always #5 clk = ~clk;

  regfile_wb_queue dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_addr  (alu_addr),
    .alu_data  (alu_data),
    .lsu_valid (lsu_valid),
    .lsu_ready (lsu_ready),
    .lsu_addr  (lsu_addr),
    .lsu_data  (lsu_data),
    .hold      (hold),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .busy      (busy),
    .count     (count)
  );

  // Reference model: the buffered requests in order, plus the write port.
  wb_req_t     q[$];
  bit          m_we, m_out_vld;
  logic [1:0]  m_waddr;
  logic [31:0] m_wdata;
  logic [31:0] m_rf [4];
  logic [31:0] rf_obs [4];
  bit          armed;
  int          n_checks, n_errors;

  // Register file as seen from the DUT's write port.
  always @(posedge clk) if (we === 1'b1) rf_obs[waddr] <= wdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] m_busy();
    logic [3:0] b = '0;
    foreach (q[i]) b[q[i].addr] = 1'b1;
    if (m_out_vld) b[m_waddr] = 1'b1;
    return b;
  endfunction

  task automatic cycle(input bit rst, input bit h,
                       input bit lv, input logic [1:0] la, input logic [31:0] ld,
                       input bit av, input logic [1:0] aa, input logic [31:0] ad);
    bit      m_lr, m_ar;
    int      fr;
    wb_req_t hd;
    @(negedge clk);
    if (armed) begin
      chk("count", count, q.size());
      chk("we", we, m_we);
      chk("waddr", waddr, m_waddr);
      chk("wdata", wdata, m_wdata);
      chk("busy", busy, m_busy());
    end
    reset_n = ~rst; hold = h;
    lsu_valid = lv; lsu_addr = la; lsu_data = ld;
    alu_valid = av; alu_addr = aa; alu_data = ad;
    #1;
    fr   = DEPTH - q.size();
    m_lr = (fr >= 1);
    m_ar = (fr >= 2) || (fr >= 1 && !lv);
    if (armed) begin
      chk("lsu_ready", lsu_ready, m_lr);
      chk("alu_ready", alu_ready, m_ar);
    end
    @(posedge clk);
    if (m_we) m_rf[m_waddr] = m_wdata;
    if (rst) begin
      q.delete();
      m_we = 0; m_out_vld = 0; m_waddr = '0; m_wdata = '0;
    end else begin
      if (!h && q.size() != 0) begin
        hd = q.pop_front();
        m_we = (hd.addr != REG_ZERO);
        m_waddr = hd.addr; m_wdata = hd.data; m_out_vld = 1;
      end else begin
        m_we = 0; m_out_vld = 0;
      end
      if (lv && m_lr) q.push_back(wb_req_t'{addr: la, data: ld});
      if (av && m_ar) q.push_back(wb_req_t'{addr: aa, data: ad});
    end
  endtask

  task automatic idle(input int n, input bit h);
    for (int i = 0; i < n; i++) cycle(0, h, 0, 2'd0, 32'h0, 0, 2'd0, 32'h0);
  endtask

  initial begin
    n_checks = 0; n_errors = 0; armed = 0;
    for (int r = 0; r < 4; r++) begin m_rf[r] = '0; rf_obs[r] = '0; end
    m_we = 0; m_out_vld = 0; m_waddr = '0; m_wdata = '0;
    reset_n = 0; hold = 0; lsu_valid = 0; alu_valid = 0;
    lsu_addr = '0; alu_addr = '0; lsu_data = '0; alu_data = '0;

    cycle(1, 0, 0, 2'd0, 32'h0, 0, 2'd0, 32'h0);
    armed = 1;
    cycle(1, 0, 1, 2'd1, 32'h1111, 1, 2'd2, 32'h2222);
    #1;
    chk("reset_count", count, 0);
    chk("reset_busy", busy, 0);

    // Single ALU write
    cycle(0, 0, 0, 2'd0, 32'h0, 1, 2'd1, 32'hDEADBEEF);
    idle(4, 0);
    #1 chk("rf1_single", rf_obs[1], 32'hDEADBEEF);

    // LSU and ALU to the same register: LSU goes first, ALU wins
    cycle(0, 0, 1, 2'd2, 32'hCAFEBABE, 1, 2'd2, 32'h12345678);
    idle(4, 0);
    #1 chk("rf2_order", rf_obs[2], 32'h12345678);

    // Hold with five ALU requests: four fit
    for (int i = 1; i <= 5; i++) cycle(0, 1, 0, 2'd0, 32'h0, 1, 2'd3, 32'(i));
    #1 chk("hold_count", count, 4);
    chk("hold_alu_ready", alu_ready, 0);
    idle(6, 0);
    #1 chk("rf3_drain", rf_obs[3], 32'd4);

    // free=1 with both producers: only the LSU entry enters
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 2'd0, 32'h0, 1, 2'd1, 32'h11 * (i + 1));
    cycle(0, 1, 1, 2'd2, 32'h44, 1, 2'd3, 32'h55);
    #1 chk("free1_count", count, 4);
    idle(7, 0);
    #1 chk("rf2_lsu_only", rf_obs[2], 32'h44);
    chk("rf3_alu_rejected", rf_obs[3], 32'd4);

    // Address zero is retired without a write
    cycle(0, 0, 0, 2'd0, 32'h0, 1, 2'd0, 32'hFFFFFFFF);
    idle(4, 0);
    #1 chk("rf0_dropped", rf_obs[0], 32'h0);

    // Reset with entries buffered discards them
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 2'd0, 32'h0, 1, 2'(i + 1), 32'hA0 + 32'(i));
    cycle(1, 1, 0, 2'd0, 32'h0, 0, 2'd0, 32'h0);
    idle(4, 0);
    #1;
    for (int r = 0; r < 4; r++) chk($sformatf("rf%0d_after_reset", r), rf_obs[r], m_rf[r]);

    // Random traffic
    for (int i = 0; i < 3000; i++)
      cycle(($urandom % 64) == 0, ($urandom % 4) == 0,
            ($urandom % 2) == 0, 2'($urandom), $urandom,
            ($urandom % 5) < 3, 2'($urandom), $urandom);
    idle(8, 0);
    #1;
    for (int r = 0; r < 4; r++) chk($sformatf("rf%0d_final", r), rf_obs[r], m_rf[r]);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
